// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with a pending-write scoreboard.
// Same-cycle write-to-read bypass is compiled in only when REGFILE_MP_BYPASS_EN is defined.
package rapid_pkg;
  localparam logic [31:0] RESET_STACK_POINTER = 32'h0000_FFFC;
endpackage

module regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRP      = 2,
  parameter int unsigned SP_IDX   = 2,
  parameter logic [XLEN-1:0] SP_RESET = XLEN'(rapid_pkg::RESET_STACK_POINTER),
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [NRP*AW-1:0]   i_rs_addr,
  output logic [NRP*XLEN-1:0] o_rs_data,
  output logic [NRP-1:0]      o_rs_busy,
  input  logic                i_wa_en,
  input  logic [AW-1:0]       i_wa_addr,
  input  logic [XLEN-1:0]     i_wa_data,
  input  logic                i_wb_en,
  input  logic [AW-1:0]       i_wb_addr,
  input  logic [XLEN-1:0]     i_wb_data,
  input  logic                i_iss_en,
  input  logic [AW-1:0]       i_iss_rd,
  input  logic                i_flush,
  output logic [AW:0]         o_busy_cnt
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [AW:0]      r_busy_cnt;
  logic [AW:0]      w_busy_cnt_nxt;

  // Register array; load writeback (port B) wins over ALU writeback on a shared address.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= (i == SP_IDX && i != 0) ? SP_RESET : '0;
      end
    end else begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        if (i_wb_en && i_wb_addr == AW'(i)) begin
          r_regs[i] <= i_wb_data;
        end else if (i_wa_en && i_wa_addr == AW'(i)) begin
          r_regs[i] <= i_wa_data;
        end
      end
    end
  end

  // Scoreboard next state: writes clear, issue sets over writes, flush clears everything.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_wa_en) begin
      w_busy_nxt[i_wa_addr] = 1'b0;
    end
    if (i_wb_en) begin
      w_busy_nxt[i_wb_addr] = 1'b0;
    end
    if (i_iss_en) begin
      w_busy_nxt[i_iss_rd] = 1'b1;
    end
    if (i_flush) begin
      w_busy_nxt = '0;
    end
    w_busy_nxt[0] = 1'b0;

    w_busy_cnt_nxt = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      w_busy_cnt_nxt = w_busy_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
    end
  end

  assign o_busy_cnt = r_busy_cnt;

  for (genvar k = 0; k < NRP; k++) begin : g_rp
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_busy;

    assign w_addr = i_rs_addr[k*AW +: AW];

    always_comb begin
      w_data = (w_addr == '0) ? '0 : r_regs[w_addr];
      w_busy = r_busy[w_addr];
`ifdef REGFILE_MP_BYPASS_EN
      // Forward in-flight writeback; a matching write retires the pending flag unless re-issued.
      if (w_addr != '0) begin
        if (i_wb_en && i_wb_addr == w_addr) begin
          w_data = i_wb_data;
        end else if (i_wa_en && i_wa_addr == w_addr) begin
          w_data = i_wa_data;
        end
        if (((i_wa_en && i_wa_addr == w_addr) || (i_wb_en && i_wb_addr == w_addr)) &&
            !(i_iss_en && i_iss_rd == w_addr)) begin
          w_busy = 1'b0;
        end
      end
`endif
    end

    assign o_rs_data[k*XLEN +: XLEN] = w_data;
    assign o_rs_busy[k]              = w_busy;
  end

endmodule
